frame_sequencer: RTL and testbench

- Controls the threshold image reader for one or more back-to-back frame passes.
- Drives the reader's active-low reset, then latches and holds the threshold value for each frame and gates the downstream writer.
- Monitors the reader's vsync, data-phase and done signals, counting lines and pixel pairs and enforcing a watchdog.
- Sits between the testbench/host control and the reader/writer pair.

---
 rtl/frame_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: multi-frame control for the threshold reader/writer pair.
// Optional FRAME_STATS_EN adds last_Pair_Count and max_Gap statistics.
module frame_sequencer #(
  parameter int IMAGE_WIDTH     = 768,
  parameter int IMAGE_HEIGHT    = 512,
  parameter int RESET_HOLD      = 4,
  parameter int GAP_CYCLES      = 16,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] num_Frames,
  input  logic [7:0] threshold_In,
  input  logic       abort,
  output logic       reader_Reset_n,
  input  logic       reader_Vsync,
  input  logic       reader_Data_Valid,
  input  logic       reader_Done,
  output logic [7:0] threshold_Out,
  output logic       writer_Enable,
  output logic       busy,
  output logic       frame_Done,
  output logic [7:0] frames_Completed,
  output logic       error,
  output logic [1:0] error_Code
`ifdef FRAME_STATS_EN
  ,
  output logic [19:0] last_Pair_Count,
  output logic [15:0] max_Gap
`endif
);

  localparam int PAIRS = IMAGE_WIDTH / 2;
  localparam int PW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int LW = $clog2(IMAGE_HEIGHT + 1);
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT,
    S_RUN,
    S_GAP
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [PW-1:0] pair_cnt;
  logic [LW-1:0] line_cnt;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [WW-1:0] wd_cnt;
  logic [7:0]    frames_Target;
  logic          vsync_q;

  logic [PW-1:0] pair_nx;
  logic [LW-1:0] line_nx;
  logic          vs_rise;
  logic          activity;
  logic          wd_fire;
  logic          frame_good;
  logic [1:0]    fault_code;

  // Counts after this cycle's valid, plus watchdog and edge detection
  always_comb begin
    vs_rise  = reader_Vsync & ~vsync_q;
    activity = (reader_Vsync ^ vsync_q) | reader_Data_Valid;
    wd_fire  = !activity && (wd_cnt == WW'(WATCHDOG_CYCLES - 1));
    pair_nx  = pair_cnt;
    line_nx  = line_cnt;
    if (reader_Data_Valid) begin
      if (pair_cnt == PW'(PAIRS - 1)) begin
        pair_nx = '0;
        if (line_cnt != '1) line_nx = line_cnt + 1'b1;
      end else begin
        pair_nx = pair_cnt + 1'b1;
      end
    end
    frame_good = (line_nx == LW'(IMAGE_HEIGHT)) && (pair_nx == '0);
  end

  // Next-state decision; abort overrides everything outside IDLE
  always_comb begin
    nxt        = state;
    fault_code = 2'b00;
    unique case (state)
      S_IDLE: if (start && !abort) nxt = S_HOLD;
      S_HOLD: if (hold_cnt == HW'(RESET_HOLD - 1)) nxt = S_WAIT;
      S_WAIT: begin
        if (wd_fire) begin
          nxt        = S_IDLE;
          fault_code = 2'b01;
        end else if (vs_rise) begin
          nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (wd_fire) begin
          nxt        = S_IDLE;
          fault_code = 2'b01;
        end else if (reader_Done) begin
          if (frame_good) begin
            nxt = S_GAP;
          end else begin
            nxt        = S_IDLE;
            fault_code = 2'b10;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1))
          nxt = (frames_Completed < frames_Target) ? S_HOLD : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    if (state != S_IDLE && abort) begin
      nxt        = S_IDLE;
      fault_code = 2'b11;
    end
  end

  // State register, registered outputs and per-state counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      reader_Reset_n   <= 1'b0;
      threshold_Out    <= '0;
      writer_Enable    <= 1'b0;
      busy             <= 1'b0;
      frame_Done       <= 1'b0;
      frames_Completed <= '0;
      error            <= 1'b0;
      error_Code       <= 2'b00;
      frames_Target    <= '0;
      pair_cnt         <= '0;
      line_cnt         <= '0;
      hold_cnt         <= '0;
      gap_cnt          <= '0;
      wd_cnt           <= '0;
      vsync_q          <= 1'b0;
    end else begin
      state          <= nxt;
      vsync_q        <= reader_Vsync;
      reader_Reset_n <= (nxt == S_WAIT) || (nxt == S_RUN);
      writer_Enable  <= (nxt == S_RUN);
      busy           <= (nxt != S_IDLE);
      frame_Done     <= 1'b0;

      if (state == S_IDLE && nxt == S_HOLD) begin
        frames_Target    <= (num_Frames == 8'd0) ? 8'd1 : num_Frames;
        frames_Completed <= '0;
        error            <= 1'b0;
        error_Code       <= 2'b00;
      end

      if (fault_code != 2'b00) begin
        error      <= 1'b1;
        error_Code <= fault_code;
      end

      if (state == S_RUN && nxt == S_GAP) begin
        frame_Done <= 1'b1;
        if (frames_Completed != 8'hFF)
          frames_Completed <= frames_Completed + 8'd1;
      end

      if (state != S_HOLD && nxt == S_HOLD) begin
        threshold_Out <= threshold_In;
        hold_cnt      <= '0;
      end else if (state == S_HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end

      if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
      else gap_cnt <= '0;

      if (state == S_RUN) begin
        pair_cnt <= pair_nx;
        line_cnt <= line_nx;
      end else begin
        pair_cnt <= '0;
        line_cnt <= '0;
      end

      if (nxt != state || activity ||
          !(state == S_WAIT || state == S_RUN))
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

`ifdef FRAME_STATS_EN
  logic [19:0] run_pairs;
  logic [15:0] idle_run;
  logic [15:0] idle_inc;

  // Saturating length of the current idle stretch
  always_comb begin
    idle_inc = (idle_run == 16'hFFFF) ? idle_run : idle_run + 16'd1;
  end

  // Pair total per RUN and longest idle stretch inside RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_pairs       <= '0;
      idle_run        <= '0;
      last_Pair_Count <= '0;
      max_Gap         <= '0;
    end else begin
      if (state == S_IDLE && nxt == S_HOLD) max_Gap <= '0;
      if (state != S_RUN) begin
        run_pairs <= '0;
        idle_run  <= '0;
      end else begin
        if (reader_Data_Valid) begin
          run_pairs <= run_pairs + 20'd1;
          idle_run  <= '0;
        end else begin
          idle_run <= idle_inc;
          if (idle_inc > max_Gap) max_Gap <= idle_inc;
        end
        if (nxt != S_RUN)
          last_Pair_Count <= run_pairs + 20'(reader_Data_Valid);
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: randomized directed bench with a frame-level model.
// Expected outcomes come from pair totals and cycle budgets.
module tb_frame_sequencer;

  localparam int IW = 8;
  localparam int IH = 4;
  localparam int RH = 4;
  localparam int GC = 16;
  localparam int WD = 64;
  localparam int PAIRS = IW / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_Frames = '0;
  logic [7:0] threshold_In = '0;
  logic       abort = 1'b0;
  logic       reader_Reset_n;
  logic       reader_Vsync = 1'b0;
  logic       reader_Data_Valid = 1'b0;
  logic       reader_Done = 1'b0;
  logic [7:0] threshold_Out;
  logic       writer_Enable;
  logic       busy;
  logic       frame_Done;
  logic [7:0] frames_Completed;
  logic       error;
  logic [1:0] error_Code;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_fc = 0;

  frame_sequencer #(
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .RESET_HOLD(RH),
    .GAP_CYCLES(GC), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .num_Frames(num_Frames), .threshold_In(threshold_In),
    .abort(abort), .reader_Reset_n(reader_Reset_n),
    .reader_Vsync(reader_Vsync),
    .reader_Data_Valid(reader_Data_Valid),
    .reader_Done(reader_Done), .threshold_Out(threshold_Out),
    .writer_Enable(writer_Enable), .busy(busy),
    .frame_Done(frame_Done),
    .frames_Completed(frames_Completed),
    .error(error), .error_Code(error_Code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_Done === 1'b1) pulses <= pulses + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rn"}, reader_Reset_n, 0);
    chk({tag, "_thr"}, threshold_Out, 0);
    chk({tag, "_we"}, writer_Enable, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fd"}, frame_Done, 0);
    chk({tag, "_fc"}, frames_Completed, 0);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_code"}, error_Code, 0);
  endtask

  task automatic do_start(input logic [7:0] nf, input logic [7:0] th);
    start = 1'b1;
    num_Frames = nf;
    threshold_In = th;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_low(output int n);
    n = 0;
    while (busy && !reader_Reset_n && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic pulse_vsync();
    reader_Vsync = 1'b1;
    tick();
    reader_Vsync = 1'b0;
  endtask

  task automatic send_valids(input int n, input bit done_last);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      reader_Data_Valid = 1'b1;
      if (i == n - 1 && done_last) reader_Done = 1'b1;
      tick();
      reader_Data_Valid = 1'b0;
      reader_Done = 1'b0;
    end
  endtask

  task automatic frame(input int nv, input logic [7:0] th2,
                       input logic [7:0] exp_th, output bit good);
    bit dl;
    good = (nv == PAIRS * IH);
    chk("wait_thr", threshold_Out, exp_th);
    pulse_vsync();
    chk("run_we", writer_Enable, 1);
    threshold_In = th2;
    dl = 1'($urandom_range(0, 1));
    send_valids(nv, dl);
    if (!dl) begin
      reader_Done = 1'b1;
      tick();
      reader_Done = 1'b0;
    end
    chk("frame_thr", threshold_Out, exp_th);
    chk("done_we", writer_Enable, 0);
    if (good) begin
      exp_fc++;
      chk("good_fd", frame_Done, 1);
      chk("good_busy", busy, 1);
      chk("good_rn", reader_Reset_n, 0);
      chk("good_fc", frames_Completed, exp_fc);
    end else begin
      chk("bad_err", error, 1);
      chk("bad_code", error_Code, 2'b10);
      chk("bad_busy", busy, 0);
      chk("bad_fd", frame_Done, 0);
    end
  endtask

  task automatic job(input logic [7:0] nf, input logic [7:0] th,
                     input int nv, input logic [7:0] th2);
    int n;
    int eff;
    int p0;
    logic [7:0] exp_th;
    bit good;
    good = 1'b0;
    eff = (nf == 8'd0) ? 1 : int'(nf);
    p0 = pulses;
    exp_fc = 0;
    exp_th = th;
    do_start(nf, th);
    chk("start_busy", busy, 1);
    chk("start_thr", threshold_Out, th);
    chk("start_err", error, 0);
    for (int f = 0; f < eff; f++) begin
      wait_low(n);
      chk("hold_len", n, (f == 0) ? RH : GC + RH);
      frame(nv, th2, exp_th, good);
      exp_th = th2;
      if (!good) break;
    end
    if (good) begin
      wait_low(n);
      chk("gap_len", n, GC);
      chk("end_busy", busy, 0);
      chk("end_fc", frames_Completed, eff);
      chk("end_err", error, 0);
    end
    chk("pulses", pulses - p0, good ? eff : 0);
    chk("idle_rn", reader_Reset_n, 0);
  endtask

  initial begin
    int n;
    int p0;
    tick();
    chk_reset_vals("rst");
    start = 1'b1;
    num_Frames = 8'd1;
    tick();
    chk("rst_start_busy", busy, 0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    job(8'd1, 8'd90, PAIRS * IH, 8'd90);
    job(8'd3, 8'd90, PAIRS * IH, 8'd120);
    job(8'd1, 8'(($urandom_range(0, 255))), PAIRS * IH - 1, 8'd0);

    for (int k = 0; k < 4; k++) begin
      logic [7:0] t;
      t = 8'($urandom_range(0, 255));
      job(8'($urandom_range(0, 2)), t,
          PAIRS * IH - 1 + int'($urandom_range(0, 2)), t);
    end

    do_start(8'd1, 8'd10);
    wait_low(n);
    chk("wd_hold", n, RH);
    n = 0;
    while (busy && reader_Reset_n && n < 200) begin
      n++;
      tick();
    end
    chk("wd_len", n, WD);
    chk("wd_err", error, 1);
    chk("wd_code", error_Code, 2'b01);
    chk("wd_busy", busy, 0);

    p0 = pulses;
    do_start(8'd1, 8'd11);
    chk("restart_err", error, 0);
    chk("restart_code", error_Code, 0);
    wait_low(n);
    pulse_vsync();
    send_valids(5, 1'b0);
    abort = 1'b1;
    reader_Done = 1'b1;
    tick();
    abort = 1'b0;
    reader_Done = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_err", error, 1);
    chk("ab_code", error_Code, 2'b11);
    chk("ab_fd", frame_Done, 0);
    chk("ab_we", writer_Enable, 0);
    tick();
    chk("ab_pulses", pulses - p0, 0);

    do_start(8'd2, 8'd55);
    wait_low(n);
    pulse_vsync();
    send_valids(3, 1'b0);
    chk("ar_run_we", writer_Enable, 1);
    #2;
    reset = 1'b1;
    start = 1'b1;
    #1;
    chk_reset_vals("ar");
    tick();
    tick();
    chk("ar_start_busy", busy, 0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    job(8'd1, 8'd77, PAIRS * IH, 8'd77);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
